pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, conditional/relative branch, call/return, sticky halt.
// Define PC_SEQUENCER_RAS_EN to build the return-address stack; otherwise call is a plain jump and ret an increment.
//
// state   | meaning
// ST_RUN  | pc advances by one action per non-stalled cycle
// ST_HALT | pc reached HALT_ADDR; everything frozen until reset
module pc_sequencer #(
   parameter int INST_WIDTH = 9,
   parameter int HALT_ADDR  = 31,
   parameter int RAS_DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  branch_en,
   input  logic [1:0]            branch_cond,
   input  logic                  branch_rel,
   input  logic                  alu_zero,
   input  logic                  alu_neg,
   input  logic [INST_WIDTH-1:0] target,
   input  logic                  call,
   input  logic                  ret,
   output logic [INST_WIDTH-1:0] pc,
   output logic                  halt,
   output logic                  ras_err
);

   typedef enum logic {ST_RUN, ST_HALT} state_t;

   state_t                  state_q, state_d;
   logic [INST_WIDTH-1:0]   pc_q, pc_d;
   logic [INST_WIDTH-1:0]   pc_inc;
   logic                    pc_at_halt;
   logic                    cond_true;
   logic                    take_branch;

   assign pc_inc     = pc_q + INST_WIDTH'(1);
   assign pc_at_halt = ({{(32-INST_WIDTH){1'b0}}, pc_q} >= 32'(HALT_ADDR));

   always_comb begin
      cond_true = 1'b0;
      unique case (branch_cond)
         2'b00: cond_true = 1'b1;
         2'b01: cond_true = alu_zero;
         2'b10: cond_true = !alu_zero;
         2'b11: cond_true = alu_neg;
         default: cond_true = 1'b0;
      endcase
   end

   assign take_branch = branch_en && cond_true;

`ifdef PC_SEQUENCER_RAS_EN
   localparam int CW = $clog2(RAS_DEPTH) + 1;
   localparam int IW = $clog2(RAS_DEPTH);

   logic [INST_WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  push_en;
   logic [IW-1:0]         push_idx, pop_idx;
   logic [CW-1:0]         cnt_dec;

   assign push_idx = cnt_q[IW-1:0];
   assign cnt_dec  = cnt_q - CW'(1);
   assign pop_idx  = cnt_dec[IW-1:0];
   assign ras_err  = err_q;
`else
   assign ras_err  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
`ifdef PC_SEQUENCER_RAS_EN
      cnt_d   = cnt_q;
      err_d   = err_q;
      push_en = 1'b0;
`endif
      if (!stall && state_q == ST_RUN) begin
         if (pc_at_halt) begin
            state_d = ST_HALT;
         end else if (ret) begin
`ifdef PC_SEQUENCER_RAS_EN
            if (call) err_d = 1'b1;
            if (cnt_q != '0) begin
               pc_d  = ras_q[pop_idx];
               cnt_d = cnt_dec;
            end else begin
               pc_d  = pc_inc;
               err_d = 1'b1;
            end
`else
            pc_d = pc_inc;
`endif
         end else if (call) begin
            pc_d = target;
`ifdef PC_SEQUENCER_RAS_EN
            // A full stack loses the return address but the jump still happens.
            if (cnt_q == CW'(RAS_DEPTH)) begin
               err_d = 1'b1;
            end else begin
               push_en = 1'b1;
               cnt_d   = cnt_q + CW'(1);
            end
`endif
         end else if (take_branch) begin
            pc_d = branch_rel ? (pc_q + target) : target;
         end else begin
            pc_d = pc_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
         pc_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

`ifdef PC_SEQUENCER_RAS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Entry contents are don't-care after reset, so no reset on the array.
   always_ff @(posedge clk) begin
      if (push_en) ras_q[push_idx] <= pc_inc;
   end
`endif

   assign pc   = pc_q;
   assign halt = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expectations follow PC_SEQUENCER_RAS_EN when defined.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       reset, stall, branch_en, branch_rel, alu_zero, alu_neg, call, ret;
   logic [1:0] branch_cond;
   logic [8:0] target;
   logic [8:0] pc;
   logic       halt, ras_err;

   int checks = 0;
   int errors = 0;

   pc_sequencer #(.INST_WIDTH(9), .HALT_ADDR(31), .RAS_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
      .branch_cond(branch_cond), .branch_rel(branch_rel), .alu_zero(alu_zero),
      .alu_neg(alu_neg), .target(target), .call(call), .ret(ret),
      .pc(pc), .halt(halt), .ras_err(ras_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; branch_en = 0; branch_cond = 2'b00; branch_rel = 0;
      alu_zero = 0; alu_neg = 0; target = '0; call = 0; ret = 0;
   endtask

   task automatic do_reset();
      reset = 1; step(); reset = 0;
   endtask

   initial begin
      reset = 1; idle();
      step(); step();
      reset = 0;
      chk("rst_pc", pc, 0);
      chk("rst_halt", halt, 0);
      chk("rst_err", ras_err, 0);

      // plain increment 0..5
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("inc_pc", pc, i);
      end
      chk("inc_halt", halt, 0);

      // conditional branches from pc=3
      do_reset(); step(); step(); step();
      chk("br_start", pc, 3);
      branch_en = 1; branch_cond = 2'b01; alu_zero = 0; target = 9'd17;
      step(); chk("br_z_untaken", pc, 4);
      branch_en = 0; step(); chk("br_gap", pc, 5);
      branch_en = 1; branch_cond = 2'b01; alu_zero = 1; branch_rel = 1; target = 9'h1FE;
      step(); chk("br_rel_back", pc, 3);

      // stall during an absolute branch request
      branch_cond = 2'b00; branch_rel = 0; target = 9'd25; stall = 1;
      for (int i = 0; i < 3; i++) begin
         step(); chk("stall_pc", pc, 3);
      end
      stall = 0;
      step(); chk("stall_release", pc, 25);
      branch_cond = 2'b10; alu_zero = 1; target = 9'd2;
      step(); chk("br_nz_untaken", pc, 26);
      branch_cond = 2'b11; alu_neg = 1; target = 9'd2;
      step(); chk("br_neg_taken", pc, 2);
      branch_cond = 2'b00; branch_rel = 1; target = 9'h1F0;
      step(); chk("br_rel_wrap", pc, 498);
      idle();
      step(); chk("halt_wrap_pc", pc, 498);
      chk("halt_wrap", halt, 1);

      // reset beats stall and requests
      stall = 1; call = 1; target = 9'd9; do_reset();
      chk("rst_prio_pc", pc, 0);
      chk("rst_prio_halt", halt, 0);
      idle();

      // single call / return
      for (int i = 0; i < 5; i++) step();
      chk("call_start", pc, 5);
      call = 1; target = 9'd20;
      step(); chk("call_pc", pc, 20);
      call = 0;
      step(); chk("call_next", pc, 21);
      ret = 1;
      step();
`ifdef PC_SEQUENCER_RAS_EN
      chk("ret_pc", pc, 6);
`else
      chk("ret_pc", pc, 22);
`endif
      chk("ret_err", ras_err, 0);
      ret = 0;

      // nested calls beyond the stack depth
      do_reset();
      call = 1;
      for (int i = 0; i < 5; i++) begin
         target = 9'(10 + i);
         step(); chk("nest_call_pc", pc, 10 + i);
`ifdef PC_SEQUENCER_RAS_EN
         chk("nest_call_err", ras_err, (i == 4) ? 1 : 0);
`else
         chk("nest_call_err", ras_err, 0);
`endif
      end
      call = 0; ret = 1;
`ifdef PC_SEQUENCER_RAS_EN
      step(); chk("nest_ret1", pc, 13);
      step(); chk("nest_ret2", pc, 12);
      step(); chk("nest_ret3", pc, 11);
      step(); chk("nest_ret4", pc, 1);
      step(); chk("nest_ret_empty", pc, 2);
      chk("nest_err_sticky", ras_err, 1);
`else
      step(); chk("nest_ret1", pc, 15);
      step(); chk("nest_ret2", pc, 16);
      chk("nest_err", ras_err, 0);
`endif
      ret = 0;

      // call and ret together
      do_reset();
      call = 1; target = 9'd10;
      step(); chk("conf_call", pc, 10);
      call = 1; ret = 1; target = 9'd20;
      step();
`ifdef PC_SEQUENCER_RAS_EN
      chk("conf_pc", pc, 1);
      chk("conf_err", ras_err, 1);
`else
      chk("conf_pc", pc, 11);
      chk("conf_err", ras_err, 0);
`endif
      idle();

      // run into the halt address
      do_reset();
      branch_en = 1; target = 9'd30;
      step(); chk("run_30", pc, 30);
      branch_en = 0;
      step(); chk("run_31", pc, 31);
      chk("run_31_halt", halt, 0);
      step(); chk("halt_pc", pc, 31);
      chk("halt_set", halt, 1);
      branch_en = 1; target = 9'd5; call = 1;
      step(); step();
      chk("halt_frozen_pc", pc, 31);
      chk("halt_sticky", halt, 1);
      do_reset();
      chk("halt_rst_pc", pc, 0);
      chk("halt_rst_halt", halt, 0);
      chk("halt_rst_err", ras_err, 0);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
